tape_ear_conditioner: RTL
=========================

TAPE_EAR_CONDITIONER -- requirements
Module: tape_ear_conditioner

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 3, meaning consecutive differing samples required before the filtered level changes (legal 1..15).
REQ-002 SHALL have parameter PWM_BITS, default 8, meaning width of the audio PWM counter and the volume input.
REQ-003 SHALL have parameter HOLD_BITS, default 16, meaning width of the activity hold counter.
REQ-004 SHALL have port clk65, input, 1, the single clock (6.5 MHz video clock domain).
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk65.
REQ-006 SHALL have port ear, input, 1, asynchronous raw tape/EAR level.
REQ-007 SHALL have port bypass, input, 1, meaning: 1 selects the synchronised unfiltered level.
REQ-008 SHALL have port invert, input, 1, meaning: 1 inverts tape_data.
REQ-009 SHALL have port volume, input, PWM_BITS, the PWM duty threshold for audio.
REQ-010 SHALL have port tape_data, output, 1, the conditioned tape level fed to the machine.
REQ-011 SHALL have port tape_edge, output, 1, a one-cycle pulse on each change of the conditioned level.
REQ-012 SHALL have port activity, output, 1, the load-activity indicator (LED drive).
REQ-013 SHALL have port audio, output, 1, the volume-limited PWM tape monitor.

Function
REQ-014 SHALL synchronise ear through two flops s1->s2, all sampled on clk65.
REQ-015 SHALL keep filtered level f and run counter cnt (4 bits): when s2==f, cnt<=0; when s2!=f and cnt==FILTER_LEN-1, f<=s2 and cnt<=0; otherwise cnt<=cnt+1.
REQ-016 SHALL, for ear stable from before edge k, update f at edge k+1+FILTER_LEN; pulses shorter than FILTER_LEN cycles at s2 SHALL never reach f.
REQ-017 SHALL define raw = bypass ? s2 : f, and SHALL keep the filter running while bypass=1.
REQ-018 SHALL drive tape_data = raw XOR invert, combinationally from registers.
REQ-019 SHALL register raw_d <= raw each cycle and drive tape_edge = (raw != raw_d); each change of raw SHALL yield exactly one high cycle. Toggling bypass while s2 != f SHALL also yield one pulse. Toggling invert SHALL never yield a pulse.
REQ-020 SHALL load hold counter hc with all-ones on a cycle with tape_edge=1; otherwise it SHALL decrement when nonzero and saturate at 0; activity = (hc != 0).
REQ-021 SHALL run pwm_cnt (PWM_BITS) freely, wrapping from all-ones to 0.
REQ-022 SHALL register audio <= tape_data AND (pwm_cnt < volume) as an unsigned compare. volume=0 SHALL give audio constantly 0. volume=all-ones SHALL give (2^PWM_BITS-1) high cycles per 2^PWM_BITS while tape_data=1.
REQ-023 SHALL let volume changes take effect on the next clk65 edge, with no glitch-suppression requirement.

Reset
REQ-024 SHALL clear s1, s2, f, cnt, raw_d, hc, pwm_cnt and audio to 0 on any clk65 edge with reset=1, including mid-filter and mid-hold.
REQ-025 SHALL hold tape_data=invert, tape_edge=0 and activity=0 during reset and on the first cycle after release.
REQ-026 SHALL restart filter counting from 0 after reset: a partially counted change SHALL be discarded.

Verification
REQ-027 SHALL cover: FILTER_LEN=3, ear 0->1 held -> f=1 at edge k+4, tape_edge high exactly one cycle, activity high for 2^16-1 cycles.
REQ-028 SHALL cover: ear high pulses of 1 and 2 cycles, FILTER_LEN=3 -> tape_data unchanged, tape_edge never asserted.
REQ-029 SHALL cover: bypass=1, ear 2-cycle pulse -> tape_data follows ear delayed 2 cycles, two tape_edge pulses; bypass 1->0 with s2!=f -> one tape_edge.
REQ-030 SHALL cover: PWM_BITS=8, tape_data=1, volume=32 -> audio high 32 of every 256 cycles; volume=0 -> 0 of 256.
REQ-031 SHALL cover: reset asserted with cnt=2 and hc nonzero -> next cycle f=0, activity=0, tape_data=invert; ear change after release takes full FILTER_LEN+1 cycles.
REQ-032 SHALL cover: invert toggled with ear static -> tape_data flips same cycle, tape_edge stays 0, activity unchanged.

Source files
------------

// File: rtl/tape_ear_conditioner.sv
// tape_ear_conditioner: EAR sync, glitch filter, edge pulse, activity hold and PWM audio monitor
//   clk65/reset : 6.5 MHz clock, sync active-high reset
//   ear         : raw async tape level
//   bypass      : 1 = use synchronised unfiltered level
//   invert      : 1 = invert tape_data
//   volume      : PWM duty threshold for audio
//   tape_data   : conditioned level; tape_edge: one-cycle pulse per level change
//   activity    : load LED drive; audio: volume-limited PWM monitor
module tape_ear_conditioner #(
  parameter int FILTER_LEN = 3,
  parameter int PWM_BITS = 8,
  parameter int HOLD_BITS = 16
) (
  input  logic                clk65,
  input  logic                reset,
  input  logic                ear,
  input  logic                bypass,
  input  logic                invert,
  input  logic [PWM_BITS-1:0] volume,
  output logic                tape_data,
  output logic                tape_edge,
  output logic                activity,
  output logic                audio
);
  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);
  logic s1, s2, f, raw, raw_d;
  logic [3:0] cnt;
  logic [HOLD_BITS-1:0] hc;
  logic [PWM_BITS-1:0] pwm_cnt;
  // edge detection works on raw so toggling invert never produces a pulse
  assign raw = bypass ? s2 : f;
  assign tape_data = raw ^ invert;
  assign tape_edge = raw != raw_d;
  assign activity = |hc;
  always_ff @(posedge clk65) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      f <= 1'b0;
      cnt <= '0;
      raw_d <= 1'b0;
      hc <= '0;
      pwm_cnt <= '0;
      audio <= 1'b0;
    end else begin
      s1 <= ear;
      s2 <= s1;
      if (s2 == f) cnt <= '0;
      else if (cnt == LAST) begin
        f <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
      raw_d <= raw;
      hc <= tape_edge ? '1 : (hc != '0 ? hc - 1'b1 : hc);
      pwm_cnt <= pwm_cnt + 1'b1;
      audio <= tape_data & (pwm_cnt < volume);
    end
  end
endmodule
